// File: rtl/c3demo_ledpanel_bcm.sv
// HUB75 LED panel driver with binary code modulation, double-buffered frame
// memory swapped at frame end, and a global per-bitplane brightness unit.
module c3demo_ledpanel_bcm #(
  parameter int COLS = 32,
  parameter int ROWS = 32,
  parameter int BITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_enable,
  input  logic [$clog2(COLS)-1:0]   wr_addr_x,
  input  logic [$clog2(ROWS)-1:0]   wr_addr_y,
  input  logic [3*BITS-1:0]         wr_rgb_data,
  input  logic                      swap_req,
  output logic                      swap_ack,
  input  logic [7:0]                brightness,
  output logic                      frame_done,
  output logic                      PANEL_R0,
  output logic                      PANEL_G0,
  output logic                      PANEL_B0,
  output logic                      PANEL_R1,
  output logic                      PANEL_G1,
  output logic                      PANEL_B1,
  output logic [$clog2(ROWS)-2:0]   PANEL_ADDR,
  output logic                      PANEL_CLK,
  output logic                      PANEL_STB,
  output logic                      PANEL_OE
);
  localparam int XB    = $clog2(COLS);
  localparam int YB    = $clog2(ROWS);
  localparam int AB    = YB - 1;
  localparam int AW    = AB + XB;
  localparam int DEPTH = (ROWS / 2) * COLS;
  localparam int PB    = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int W     = 3 * BITS;

  localparam logic [XB-1:0] COL_LAST   = XB'(COLS - 1);
  localparam logic [AB-1:0] ROW_LAST   = AB'(ROWS / 2 - 1);
  localparam logic [PB-1:0] PLANE_LAST = PB'(BITS - 1);

  typedef enum logic [2:0] {
    S_PREFETCH,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t          state_q, state_d;
  logic [XB-1:0]   col_q, col_d;
  logic            phase_q, phase_d;
  logic [AB-1:0]   row_q, row_d;
  logic [PB-1:0]   plane_q, plane_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            dark_q, dark_d;
  logic            front_q, front_d;
  logic            pending_q, pending_d;
  logic [AB-1:0]   addr_q, addr_d;

  // Bank select is the MSB of the memory index: {bank, row, col}.
  logic [W-1:0]    mem_top [0:2*DEPTH-1];
  logic [W-1:0]    mem_bot [0:2*DEPTH-1];
  logic [W-1:0]    rd_top_q, rd_bot_q;
  logic [AW-1:0]   rd_addr;
  logic            rd_en;
  logic [AW:0]     wr_idx;
  logic [15:0]     disp_len;
  logic            frame_end;

  assign wr_idx = {~front_q, wr_addr_y[AB-1:0], wr_addr_x};

  always_ff @(posedge clk) begin
    if (wr_enable) begin
      if (wr_addr_y[YB-1]) mem_bot[wr_idx] <= wr_rgb_data;
      else                 mem_top[wr_idx] <= wr_rgb_data;
    end
    if (rd_en) begin
      rd_top_q <= mem_top[{front_q, rd_addr}];
      rd_bot_q <= mem_bot[{front_q, rd_addr}];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_PREFETCH;
      col_q     <= '0;
      phase_q   <= 1'b0;
      row_q     <= '0;
      plane_q   <= '0;
      cnt_q     <= '0;
      dark_q    <= 1'b0;
      front_q   <= 1'b0;
      pending_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      phase_q   <= phase_d;
      row_q     <= row_d;
      plane_q   <= plane_d;
      cnt_q     <= cnt_d;
      dark_q    <= dark_d;
      front_q   <= front_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
    end
  end

  assign disp_len  = {8'd0, brightness} << plane_q;
  assign frame_end = (state_q == S_DISPLAY) && (cnt_q == 16'd1) &&
                     (plane_q == PLANE_LAST) && (row_q == ROW_LAST);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    phase_d    = phase_q;
    row_d      = row_q;
    plane_d    = plane_q;
    cnt_d      = cnt_q;
    dark_d     = dark_q;
    addr_d     = addr_q;
    rd_en      = 1'b0;
    rd_addr    = {row_q, col_q + XB'(1)};
    PANEL_CLK  = 1'b0;
    PANEL_STB  = 1'b0;
    PANEL_OE   = 1'b1;
    PANEL_R0   = 1'b0;
    PANEL_G0   = 1'b0;
    PANEL_B0   = 1'b0;
    PANEL_R1   = 1'b0;
    PANEL_G1   = 1'b0;
    PANEL_B1   = 1'b0;

    frame_done = frame_end;
    swap_ack   = frame_end && (pending_q || swap_req);
    front_d    = front_q ^ swap_ack;
    pending_d  = swap_ack ? 1'b0 : (pending_q || swap_req);

    case (state_q)
      S_PREFETCH: begin
        rd_en   = 1'b1;
        rd_addr = {row_q, {XB{1'b0}}};
        col_d   = '0;
        phase_d = 1'b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        PANEL_CLK = phase_q;
        for (int i = 0; i < BITS; i++) begin
          if (plane_q == PB'(i)) begin
            PANEL_R0 = rd_top_q[2*BITS+i];
            PANEL_G0 = rd_top_q[BITS+i];
            PANEL_B0 = rd_top_q[i];
            PANEL_R1 = rd_bot_q[2*BITS+i];
            PANEL_G1 = rd_bot_q[BITS+i];
            PANEL_B1 = rd_bot_q[i];
          end
        end
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          // Fetch the next column at the end of phase B so the read data
          // for the current column stays on the pins for both phases.
          phase_d = 1'b0;
          rd_en   = 1'b1;
          if (col_q == COL_LAST) state_d = S_BLANK;
          else                   col_d   = col_q + XB'(1);
        end
      end
      S_BLANK: begin
        addr_d  = row_q;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        PANEL_STB = 1'b1;
        dark_d    = (disp_len == 16'd0);
        cnt_d     = (disp_len == 16'd0) ? 16'd1 : disp_len;
        state_d   = S_DISPLAY;
      end
      S_DISPLAY: begin
        PANEL_OE = dark_q;
        cnt_d    = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = S_PREFETCH;
          if (plane_q == PLANE_LAST) begin
            plane_d = '0;
            row_d   = row_q + AB'(1);
          end else begin
            plane_d = plane_q + PB'(1);
          end
        end
      end
      default: state_d = S_PREFETCH;
    endcase
  end

  assign PANEL_ADDR = addr_q;
endmodule

// File: tb/tb_c3demo_ledpanel_bcm.sv
// Bench for c3demo_ledpanel_bcm (4x4 panel, 2 bits): per-cycle comparison
// against a scan-position model plus hand-computed timing and pixel checks.
module tb_c3demo_ledpanel_bcm;
  localparam int C  = 4;
  localparam int R  = 4;
  localparam int NB = 2;
  localparam int H  = R / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_enable;
  logic [1:0] wr_x, wr_y;
  logic [5:0] wr_data;
  logic       swap_req;
  logic [7:0] brightness;
  logic       swap_ack, frame_done;
  logic       r0, g0, b0, r1, g1, b1;
  logic [0:0] paddr;
  logic       pclk, pstb, poe;

  int n_cmp = 0;
  int n_bad = 0;

  c3demo_ledpanel_bcm #(.COLS(C), .ROWS(R), .BITS(NB)) dut (
    .clk(clk), .reset(reset), .wr_enable(wr_enable),
    .wr_addr_x(wr_x), .wr_addr_y(wr_y), .wr_rgb_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .brightness(brightness),
    .frame_done(frame_done),
    .PANEL_R0(r0), .PANEL_G0(g0), .PANEL_B0(b0),
    .PANEL_R1(r1), .PANEL_G1(g1), .PANEL_B1(b1),
    .PANEL_ADDR(paddr), .PANEL_CLK(pclk), .PANEL_STB(pstb), .PANEL_OE(poe)
  );

  always #5 clk = ~clk;

  // Model: position within the frame as (row, plane, cycle-in-plane t).
  int         m_row, m_pl, m_t, m_raw, m_addr;
  bit         m_front, m_pend, m_valid;
  logic [5:0] mem   [2][R][C];
  bit         known [2][R][C];

  function automatic int m_len();
    return (m_raw == 0) ? 1 : m_raw;
  endfunction

  function automatic bit m_frame_end();
    return (m_t >= 2*C+3) && (m_t == 2*C+3+m_len()-1) &&
           (m_pl == NB-1) && (m_row == H-1);
  endfunction

  always @(posedge clk) begin
    bit fe, ack;
    if (wr_enable) begin
      mem[!m_front][wr_y][wr_x]   = wr_data;
      known[!m_front][wr_y][wr_x] = 1'b1;
    end
    if (reset) begin
      m_row = 0; m_pl = 0; m_t = 0; m_raw = 0; m_addr = 0;
      m_front = 0; m_pend = 0; m_valid = 1;
    end else if (m_valid) begin
      fe  = m_frame_end();
      ack = fe && (m_pend || swap_req);
      if (ack) begin m_front = !m_front; m_pend = 0; end
      else m_pend = m_pend || swap_req;
      if (m_t == 2*C+1) m_addr = m_row;
      if (m_t == 2*C+2) m_raw = int'(brightness) << m_pl;
      if (m_t >= 2*C+3 && m_t == 2*C+3+m_len()-1) begin
        m_t = 0;
        if (m_pl == NB-1) begin m_pl = 0; m_row = (m_row + 1) % H; end
        else m_pl++;
      end else begin
        m_t++;
      end
    end
  end

  // Vector layout: {OE, CLK, STB, ADDR, R0, G0, B0, R1, G1, B1, done, ack}
  always @(negedge clk) begin
    logic [11:0] ev, av, mk;
    logic [5:0]  top, bot;
    int          c;
    if (m_valid) begin
      ev = 12'b1000_0000_0000;
      mk = '1;
      ev[8] = m_addr[0];
      if (m_t >= 1 && m_t <= 2*C) begin
        c = (m_t - 1) / 2;
        ev[10] = ((m_t - 1) % 2) != 0;
        top = mem[m_front][m_row][c];
        bot = mem[m_front][m_row+H][c];
        if (known[m_front][m_row][c]) begin
          ev[7] = top[4+m_pl]; ev[6] = top[2+m_pl]; ev[5] = top[m_pl];
        end else mk[7:5] = '0;
        if (known[m_front][m_row+H][c]) begin
          ev[4] = bot[4+m_pl]; ev[3] = bot[2+m_pl]; ev[2] = bot[m_pl];
        end else mk[4:2] = '0;
      end
      if (m_t == 2*C+2) ev[9] = 1'b1;
      if (m_t >= 2*C+3) ev[11] = (m_raw == 0);
      ev[1] = m_frame_end();
      ev[0] = m_frame_end() && (m_pend || swap_req);
      av = {poe, pclk, pstb, paddr, r0, g0, b0, r1, g1, b1, frame_done, swap_ack};
      n_cmp++;
      if ((av & mk) !== (ev & mk)) begin
        n_bad++;
        $display("FAIL cycle_cmp t=%0t row=%0d pl=%0d pos=%0d got %b expected %b mask %b",
                 $time, m_row, m_pl, m_t, av, ev, mk);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Leaves the caller at the negedge of the frame_done cycle.
  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 500);
    if (frame_done !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_frame_done: got timeout expected pulse");
    end
  endtask

  // From one frame_done negedge, count cycles and OE-low cycles to the next.
  task automatic measure_frame(output int period, output int oe_low);
    period = 0; oe_low = 0;
    do begin
      @(negedge clk);
      period++;
      if (poe === 1'b0) oe_low++;
    end while (frame_done !== 1'b1 && period < 500);
  endtask

  task automatic write_px(input int x, input int y, input logic [5:0] d);
    wr_enable = 1'b1; wr_x = 2'(x); wr_y = 2'(y); wr_data = d;
    step();
    wr_enable = 1'b0;
  endtask

  initial begin
    int first, last, edges, per, oel;
    logic prev;
    for (int b = 0; b < 2; b++)
      for (int y = 0; y < R; y++)
        for (int x = 0; x < C; x++) known[b][y][x] = 1'b0;
    m_valid = 0;
    reset = 1; wr_enable = 0; wr_x = 0; wr_y = 0; wr_data = 0;
    swap_req = 0; brightness = 8'd3;

    // Reset and start-up
    step();
    @(negedge clk);
    chk("reset_outputs",
        {20'd0, poe, pclk, pstb, paddr, r0, g0, b0, r1, g1, b1, frame_done, swap_ack},
        32'h800);
    step(); step();
    reset = 0;
    @(negedge clk);
    prev = pclk; edges = 0; first = -1; last = -1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (pclk !== prev) begin
        edges++;
        if (first < 0) first = i;
        last = i;
      end
      prev = pclk;
    end
    chk("startup_clk_edges", edges, 8);
    chk("startup_first_edge", first, 2);
    chk("startup_last_edge", last, 9);

    // Frame timing at brightness 3
    wait_fd();
    measure_frame(per, oel);
    chk("frame_period_b3", per, 62);
    chk("oe_low_cycles_b3", oel, 18);

    // Bitplane data: fill back bank, two marked pixels, swap mid-frame
    step();
    for (int y = 0; y < R; y++)
      for (int x = 0; x < C; x++)
        write_px(x, y, (x == 2 && y == 0) ? 6'b10_01_00 :
                       (x == 2 && y == 2) ? 6'b00_00_11 : 6'b0);
    swap_req = 1; step(); swap_req = 0;
    wait_fd();
    chk("swap_ack_at_frame_end", swap_ack, 1);
    repeat (6) @(negedge clk);
    chk("plane0_col2_pins", {r0, g0, b0, r1, g1, b1}, 6'b010_001);
    repeat (14) @(negedge clk);
    chk("plane1_col2_pins", {r0, g0, b0, r1, g1, b1}, 6'b100_001);
    wait_fd();
    chk("no_second_swap", swap_ack, 0);

    // swap_req in the frame_done cycle is taken immediately
    repeat (62) step();
    swap_req = 1;
    @(negedge clk);
    chk("same_cycle_fd", frame_done, 1);
    chk("same_cycle_ack", swap_ack, 1);
    step(); swap_req = 0;

    // Brightness zero
    brightness = 8'd0;
    wait_fd();
    measure_frame(per, oel);
    chk("frame_period_b0", per, 48);
    chk("oe_low_cycles_b0", oel, 0);

    // Reset during row 1, plane 1, column 2 (phase A)
    brightness = 8'd3;
    wait_fd();
    wait_fd();
    repeat (51) step();
    chk("pre_reset_clk_low", pclk, 0);
    reset = 1;
    step();
    @(negedge clk);
    chk("midframe_reset_outputs",
        {20'd0, poe, pclk, pstb, paddr, r0, g0, b0, r1, g1, b1, frame_done, swap_ack},
        32'h800);
    step(); reset = 0;
    step();
    swap_req = 1; step(); swap_req = 0;
    wait_fd();
    chk("post_reset_swap_ack", swap_ack, 1);
    repeat (6) @(negedge clk);
    chk("post_reset_pixels", {r0, g0, b0, r1, g1, b1}, 6'b010_001);

    // Randomized traffic checked by the per-cycle model
    for (int i = 0; i < 4000; i++) begin
      step();
      wr_enable  = ($urandom_range(1, 0) == 1);
      wr_x       = 2'($urandom_range(3, 0));
      wr_y       = 2'($urandom_range(3, 0));
      wr_data    = 6'($urandom);
      swap_req   = ($urandom_range(99, 0) < 2);
      reset      = ($urandom_range(999, 0) < 2);
      if ($urandom_range(99, 0) == 0) brightness = 8'($urandom_range(5, 0));
    end
    step();
    wr_enable = 0; swap_req = 0; reset = 0;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
